seq_divider_32x16: RTL

SEQ_DIVIDER_32X16 -- requirements
Module: seq_divider_32x16

---
 rtl/div_pkg.sv | 6 +
 rtl/div_step.sv | 15 +
 rtl/seq_divider_32x16.sv | 73 +++++++
 3 files changed

// File: rtl/div_pkg.sv
// div_pkg: shared state encoding and constants for the sequential divider
package div_pkg;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  localparam int DIV_N = 16;
  localparam logic [63:0] OVF_Q = '1;
endpackage

// File: rtl/div_step.sv
// div_step: one restoring-division compare-subtract-shift step
module div_step #(
  parameter int N = 16
) (
  input  logic [N:0]   r,
  input  logic         din,
  input  logic [N-1:0] d,
  output logic [N:0]   r_next,
  output logic         q_bit
);
  logic [N+1:0] sh;
  assign sh = {r, din};
  assign q_bit = sh >= (N+2)'(d);
  assign r_next = (N+1)'(q_bit ? sh - (N+2)'(d) : sh);
endmodule

// File: rtl/seq_divider_32x16.sv
// seq_divider_32x16: restoring 2N/N divider, one quotient bit per clock, valid/ready handshake
module seq_divider_32x16
  import div_pkg::*;
#(
  parameter int N = DIV_N
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2*N-1:0] dividend,
  input  logic [N-1:0]   divisor,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [N-1:0]   quotient,
  output logic [N-1:0]   remainder,
  output logic           ovf
);
  localparam int CW = $clog2(N + 1);
  state_t        state;
  logic [CW-1:0] cnt;
  logic [N:0]    r, r_next;
  logic [N-1:0]  d, lo;
  logic          q_bit;
  div_step #(.N(N)) u_step (.r(r), .din(lo[N-1]), .d(d), .r_next(r_next), .q_bit(q_bit));
  assign in_ready  = state == IDLE;
  assign quotient  = lo;
  assign remainder = r[N-1:0];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      r         <= '0;
      d         <= '0;
      lo        <= '0;
      out_valid <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (in_valid) begin
          d   <= divisor;
          cnt <= CW'(N - 1);
          if (dividend[2*N-1:N] >= divisor) begin
            state     <= DONE;
            out_valid <= 1'b1;
            ovf       <= 1'b1;
            lo        <= OVF_Q[N-1:0];
            r         <= '0;
          end else begin
            state <= CALC;
            ovf   <= 1'b0;
            lo    <= dividend[N-1:0];
            r     <= {1'b0, dividend[2*N-1:N]};
          end
        end
        CALC: begin
          r   <= r_next;
          lo  <= {lo[N-2:0], q_bit};
          cnt <= cnt - 1'b1;
          if (cnt == '0) begin
            state     <= DONE;
            out_valid <= 1'b1;
          end
        end
        DONE: if (out_ready) begin
          state     <= IDLE;
          out_valid <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
